rca_selftest: RTL and testbench



---
 rtl/rca_selftest.sv | 142 ++++++++++++++
 tb/tb_rca_selftest.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rca_selftest.sv
// rca_selftest: exhaustive hardware tester for an external WIDTH-bit
// ripple-carry adder. It steps through every {Cin, A, B} combination and
// drives each one onto the adder. It samples the adder's sum and carry-out
// and compares them with an internal reference sum. At the end it reports
// pass/fail, the error count and the first failing vector.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   start             begin a run (accepted only when not busy)
//   A_out/B_out/Cin_out  operands to the adder under test
//   S_in/Cout_in      result returned by the adder under test
//   busy, done, pass  run status; pass valid while done
//   err_count         number of mismatching vectors in this run
//   first_fail_valid  at least one mismatch seen in this run
//   first_fail_vec    vector index {Cin,A,B} of the first mismatch
module rca_selftest #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     B_out,
  output logic                 Cin_out,
  input  logic [WIDTH-1:0]     S_in,
  input  logic                 Cout_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic                 first_fail_valid,
  output logic [2*WIDTH:0]     first_fail_vec
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t        state, state_nx;
  logic [VW-1:0] v;
  logic [CW-1:0] cnt;
  logic [EW-1:0] errs;
  logic          ffv;
  logic [VW-1:0] ffvec;

  logic [WIDTH:0] exp_sum;
  logic           mismatch;
  logic           last;
  logic           settled;
  logic           launch;

  // Reference sum at WIDTH+1 bits so the carry-out is checked as well
  always_comb begin
    exp_sum  = {1'b0, v[2*WIDTH-1:WIDTH]} + {1'b0, v[WIDTH-1:0]}
             + {{WIDTH{1'b0}}, v[2*WIDTH]};
    mismatch = ({Cout_in, S_in} != exp_sum);
    last     = (v == '1);
    settled  = (cnt == CW'(SETTLE - 1));
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    launch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (settled) state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = last ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          launch   = 1'b1;
          state_nx = DRIVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      v     <= '0;
      cnt   <= '0;
      errs  <= '0;
      ffv   <= 1'b0;
      ffvec <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        v     <= '0;
        cnt   <= '0;
        errs  <= '0;
        ffv   <= 1'b0;
        ffvec <= '0;
      end else begin
        unique case (state)
          DRIVE: if (!settled) cnt <= cnt + 1'b1;
          CHECK: begin
            if (mismatch) begin
              errs <= errs + 1'b1;
              if (!ffv) begin
                ffv   <= 1'b1;
                ffvec <= v;
              end
            end
            // v parks on the last vector so DONE keeps showing it
            if (!last) begin
              v   <= v + 1'b1;
              cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign B_out            = v[WIDTH-1:0];
  assign A_out            = v[2*WIDTH-1:WIDTH];
  assign Cin_out          = v[2*WIDTH];
  assign pass             = done && (errs == '0);
  assign err_count        = errs;
  assign first_fail_valid = ffv;
  assign first_fail_vec   = ffvec;

endmodule

// File: tb/tb_rca_selftest.sv
module tb_rca_selftest;

  localparam int W = 2;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  int   fmode = 0;
  logic sel = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [W-1:0] a1, b1, s1, a3, b3, s3;
  logic         c1, co1, c3, co3;
  logic         busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;
  logic [5:0]   ec1, ec3;
  logic [4:0]   ffvec1, ffvec3;

  // Adder under test, with an optional planted fault
  function automatic int adder_out(input int a, input int b, input int c, input int mode);
    int sum;
    sum = a + b + c;
    if (mode == 1) sum = sum & 3;       // carry-out stuck at 0
    else if (mode == 2) sum = sum ^ 1;  // sum bit 0 inverted
    return sum;
  endfunction

  assign {co1, s1} = 3'(adder_out(int'(a1), int'(b1), int'(c1), fmode));
  assign {co3, s3} = 3'(adder_out(int'(a3), int'(b3), int'(c3), fmode));

  rca_selftest #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .reset(rst), .start(start1),
    .A_out(a1), .B_out(b1), .Cin_out(c1), .S_in(s1), .Cout_in(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  rca_selftest #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .reset(rst), .start(start3),
    .A_out(a3), .B_out(b3), .Cin_out(c3), .S_in(s3), .Cout_in(co3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
  );

  // View of whichever instance is under test
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [5:0] o_ec;
  logic [4:0] o_ffvec, o_vec;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_done  = sel ? done3 : done1;
  assign o_pass  = sel ? pass3 : pass1;
  assign o_ffv   = sel ? ffv3  : ffv1;
  assign o_ec    = sel ? ec3   : ec1;
  assign o_ffvec = sel ? ffvec3 : ffvec1;
  assign o_vec   = sel ? {c3, a3, b3} : {c1, a1, b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic val);
    if (sel) start3 = val;
    else start1 = val;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vec"},   32'(o_vec), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_done"},  32'(o_done), 0);
    chk({tag, "_pass"},  32'(o_pass), 0);
    chk({tag, "_ec"},    32'(o_ec), 0);
    chk({tag, "_ffv"},   32'(o_ffv), 0);
    chk({tag, "_ffvec"}, 32'(o_ffvec), 0);
  endtask

  // Full run: start, per-cycle vector/status checks, final result checks
  task automatic run(input int settle, input int mode, input bit spam);
    int ne, ff, vi, a, b, c;
    fmode = mode;
    ne = 0;
    ff = 0;
    for (int v = 0; v < N; v++) begin
      b = v % 4;
      a = (v / 4) % 4;
      c = v / 16;
      if (adder_out(a, b, c, mode) != a + b + c) begin
        if (ne == 0) ff = v;
        ne++;
      end
    end
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int t = 0; t < N * (settle + 1); t++) begin
      vi = t / (settle + 1);
      chk("run_busy", 32'(o_busy), 1);
      chk("run_done", 32'(o_done), 0);
      chk("run_vec", 32'(o_vec), 32'(vi));
      if (t == 0) chk("run_ec_cleared", 32'(o_ec), 0);
      if (spam) set_start(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      tick();
    end
    set_start(1'b0);
    chk("end_done", 32'(o_done), 1);
    chk("end_busy", 32'(o_busy), 0);
    chk("end_pass", 32'(o_pass), (ne == 0) ? 1 : 0);
    chk("end_ec", 32'(o_ec), 32'(ne));
    chk("end_ffv", 32'(o_ffv), (ne > 0) ? 1 : 0);
    chk("end_ffvec", 32'(o_ffvec), 32'(ff));
    chk("end_vec", 32'(o_vec), N - 1);
    repeat ($urandom_range(0, 3)) tick();
    chk("hold_done", 32'(o_done), 1);
  endtask

  initial begin
    #2;
    sel = 1'b0;
    chk_reset_state("rst1");
    sel = 1'b1;
    chk_reset_state("rst3");
    #10;
    rst = 1'b0;
    tick();
    sel = 1'b0;
    chk_reset_state("idle1");

    run(1, 0, 1'b0);
    run(1, 1, 1'b0);
    run(1, 0, 1'b1);   // restart from DONE after 16 errors, start spammed
    run(1, 2, 1'b0);

    // Asynchronous reset in the middle of vector 10
    fmode = 1;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (20) tick();
    chk("pre_rst_vec", 32'(o_vec), 10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    rst = 1'b0;
    tick();
    chk_reset_state("postrst");
    run(1, 0, 1'b0);

    for (int i = 0; i < 3; i++) run(1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    sel = 1'b1;
    run(3, 0, 1'b0);
    run(3, int'($urandom_range(1, 2)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
